// File: rtl/sd_init_sequencer.sv
// SD card power-up / identification sequencer: drives CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3, CMD7
// through a single-command CMD-line controller, then reports card type and RCA.
module sd_init_sequencer #(
    parameter logic [15:0] SLOW_CLKDIV    = 16'd63,
    parameter logic [15:0] FAST_CLKDIV    = 16'd1,
    parameter logic [15:0] INIT_PRECYCLES = 16'd80,
    parameter logic [15:0] CMD_PRECYCLES  = 16'd8,
    parameter logic [15:0] ACMD41_RETRIES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_start,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_ok,
    output logic [3:0]  err_code,
    output logic        card_v2,
    output logic        card_sdhc,
    output logic [15:0] card_rca,
    output logic        cmd_start,
    output logic [15:0] cmd_precycles,
    output logic [15:0] cmd_clkdiv,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    input  logic        cmd_busy,
    input  logic        cmd_done,
    input  logic        cmd_timeout,
    input  logic        cmd_syntaxerr,
    input  logic [31:0] cmd_resparg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] ST_CMD0   = 3'd0;
    localparam logic [2:0] ST_CMD8   = 3'd1;
    localparam logic [2:0] ST_CMD55  = 3'd2;
    localparam logic [2:0] ST_ACMD41 = 3'd3;
    localparam logic [2:0] ST_CMD2   = 3'd4;
    localparam logic [2:0] ST_CMD3   = 3'd5;
    localparam logic [2:0] ST_CMD7   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [15:0] retry_q, retry_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [3:0]  err_q, err_d;
    logic        v2_q, v2_d;
    logic        sdhc_q, sdhc_d;
    logic [15:0] rca_q, rca_d;
    logic [15:0] pre_q, pre_d;
    logic [15:0] div_q, div_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        rsp_to_q, rsp_to_d;
    logic        rsp_se_q, rsp_se_d;
    logic [15:0] rsp_hi_q, rsp_hi_d;
    logic [11:0] rsp_lo_q, rsp_lo_d;
    logic [3:0]  fail_code;
    logic        seq_ok;
    logic        unused_resp;

    // Response bits 15:12 carry nothing any step of this sequence looks at.
    assign unused_resp = ^cmd_resparg[15:12];

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        retry_d   = retry_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ok_d      = ok_q;
        err_d     = err_q;
        v2_d      = v2_q;
        sdhc_d    = sdhc_q;
        rca_d     = rca_q;
        pre_d     = pre_q;
        div_d     = div_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        rsp_to_d  = rsp_to_q;
        rsp_se_d  = rsp_se_q;
        rsp_hi_d  = rsp_hi_q;
        rsp_lo_d  = rsp_lo_q;
        fail_code = 4'd0;
        seq_ok    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    busy_d  = 1'b1;
                    ok_d    = 1'b0;
                    err_d   = 4'd0;
                    v2_d    = 1'b0;
                    sdhc_d  = 1'b0;
                    rca_d   = 16'h0;
                    div_d   = SLOW_CLKDIV;
                    retry_d = 16'h0;
                    step_d  = ST_CMD0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: if (!cmd_busy) state_d = S_WAIT;
            S_WAIT: begin
                if (cmd_busy && cmd_done) begin
                    rsp_to_d = cmd_timeout;
                    rsp_se_d = cmd_syntaxerr;
                    rsp_hi_d = cmd_resparg[31:16];
                    rsp_lo_d = cmd_resparg[11:0];
                    state_d  = S_EVAL;
                end
            end
            S_EVAL: begin
                case (step_q)
                    ST_CMD0: step_d = ST_CMD8;
                    ST_CMD8: begin
                        if (rsp_to_q)                 step_d = ST_CMD55;
                        else if (rsp_se_q)            fail_code = 4'd2;
                        else if (rsp_lo_q == 12'h1AA) begin
                            v2_d   = 1'b1;
                            step_d = ST_CMD55;
                        end else                      fail_code = 4'd1;
                    end
                    ST_CMD55: begin
                        if (rsp_to_q || rsp_se_q) fail_code = 4'd7;
                        else                      step_d = ST_ACMD41;
                    end
                    ST_ACMD41: begin
                        if (rsp_to_q)         fail_code = 4'd3;
                        else if (rsp_hi_q[15]) begin
                            sdhc_d = v2_q & rsp_hi_q[14];
                            step_d = ST_CMD2;
                        end else begin
                            retry_d = retry_q + 16'd1;
                            if (retry_d == ACMD41_RETRIES) fail_code = 4'd3;
                            else                           step_d = ST_CMD55;
                        end
                    end
                    ST_CMD2: begin
                        if (rsp_to_q) fail_code = 4'd4;
                        else          step_d = ST_CMD3;
                    end
                    ST_CMD3: begin
                        if (rsp_to_q || rsp_se_q) fail_code = 4'd5;
                        else begin
                            rca_d  = rsp_hi_q;
                            step_d = ST_CMD7;
                        end
                    end
                    ST_CMD7: begin
                        if (rsp_to_q || rsp_se_q) fail_code = 4'd6;
                        else                      seq_ok = 1'b1;
                    end
                    default: fail_code = 4'd7;
                endcase

                if (fail_code != 4'd0 || seq_ok) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ok_d    = seq_ok;
                    err_d   = fail_code;
                    div_d   = seq_ok ? FAST_CLKDIV : SLOW_CLKDIV;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Command fields are loaded once on entry to ISSUE and held through WAIT.
        if (state_d == S_ISSUE && state_q != S_ISSUE) begin
            pre_d = CMD_PRECYCLES;
            arg_d = 32'h0;
            case (step_d)
                ST_CMD0:   begin idx_d = 6'd0;  pre_d = INIT_PRECYCLES; end
                ST_CMD8:   begin idx_d = 6'd8;  arg_d = 32'h0000_01AA; end
                ST_CMD55:  idx_d = 6'd55;
                ST_ACMD41: begin idx_d = 6'd41; arg_d = v2_d ? 32'h4010_0000 : 32'h0010_0000; end
                ST_CMD2:   idx_d = 6'd2;
                ST_CMD3:   idx_d = 6'd3;
                ST_CMD7:   begin idx_d = 6'd7;  arg_d = {rca_d, 16'h0}; end
                default:   idx_d = 6'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= ST_CMD0;
            retry_q  <= 16'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 4'd0;
            v2_q     <= 1'b0;
            sdhc_q   <= 1'b0;
            rca_q    <= 16'h0;
            pre_q    <= INIT_PRECYCLES;
            div_q    <= SLOW_CLKDIV;
            idx_q    <= 6'd0;
            arg_q    <= 32'h0;
            rsp_to_q <= 1'b0;
            rsp_se_q <= 1'b0;
            rsp_hi_q <= 16'h0;
            rsp_lo_q <= 12'h0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            retry_q  <= retry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            v2_q     <= v2_d;
            sdhc_q   <= sdhc_d;
            rca_q    <= rca_d;
            pre_q    <= pre_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            arg_q    <= arg_d;
            rsp_to_q <= rsp_to_d;
            rsp_se_q <= rsp_se_d;
            rsp_hi_q <= rsp_hi_d;
            rsp_lo_q <= rsp_lo_d;
        end
    end

    // Start is gated by the live busy so the pulse cannot overlap an outstanding command.
    assign cmd_start     = (state_q == S_ISSUE) && !cmd_busy;
    assign init_busy     = busy_q;
    assign init_done     = done_q;
    assign init_ok       = ok_q;
    assign err_code      = err_q;
    assign card_v2       = v2_q;
    assign card_sdhc     = sdhc_q;
    assign card_rca      = rca_q;
    assign cmd_precycles = pre_q;
    assign cmd_clkdiv    = div_q;
    assign cmd_idx       = idx_q;
    assign cmd_arg       = arg_q;

endmodule
